ad5302_cmd_seq: RTL and testbench

AD5302_CMD_SEQ -- requirements
Module: ad5302_cmd_seq

---
 rtl/ad5302_cmd_seq_pkg.sv | 37 +++
 rtl/ad5302_cmd_seq_refresh_tick.sv | 28 ++
 rtl/ad5302_cmd_seq.sv | 129 ++++++++++++
 tb/tb_ad5302_cmd_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad5302_cmd_seq_pkg.sv
// Shared definitions for the AD5302 command sequencer: FSM states, command-word
// field layout, channel codes and the word builder.
package ad5302_cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_A,
    SEND_B,
    FINISH
  } state_t;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned CH_BIT   = 15;
  localparam int unsigned BUF_BIT  = 14;
  localparam int unsigned PD_LSB   = 12;
  localparam int unsigned DATA_LSB = 4;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  function automatic logic [WORD_W-1:0] build_word(
    input logic       ch,
    input logic       buf_en,
    input logic [1:0] pd,
    input logic [7:0] data
  );
    logic [WORD_W-1:0] w;
    w                 = '0;
    w[CH_BIT]         = ch;
    w[BUF_BIT]        = buf_en;
    w[PD_LSB +: 2]    = pd;
    w[DATA_LSB +: 8]  = data;
    return w;
  endfunction

endpackage

// File: rtl/ad5302_cmd_seq_refresh_tick.sv
// Free-running period counter; tick is high in the cycle the counter wraps.
// PERIOD = 0 holds the counter at zero and never ticks.
module refresh_tick #(
  parameter int unsigned PERIOD = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]   LAST = (PERIOD > 1) ? CW'(PERIOD - 1) : '0;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || (PERIOD == 0)) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (PERIOD != 0) && (count == LAST);

endmodule

// File: rtl/ad5302_cmd_seq.sv
// AD5302 command sequencer: turns setpoint updates and periodic refreshes into
// one or two 16-bit DAC command words over a valid/ready stream.
module ad5302_cmd_seq
  import ad5302_cmd_seq_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 12_500_000,
  parameter int unsigned DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update,
  input  logic              force_all,
  input  logic [7:0]        dac_a,
  input  logic [7:0]        dac_b,
  input  logic              buf_en,
  input  logic [1:0]        pd_mode,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              busy,
  output logic              done
);

  state_t state, state_nxt;

  logic              refresh_hit;
  logic              req_now, req_force_now, take_req;
  logic              pend, pend_force, cur_force;
  logic              first_wr;
  logic [7:0]        snap_a, snap_b, last_a, last_b;
  logic              snap_buf, sel_b;
  logic [1:0]        snap_pd;
  logic              ld_sel_a, ld_sel_b;
  logic [WORD_W-1:0] word;

  refresh_tick #(.PERIOD(REFRESH_CYCLES)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .tick (refresh_hit)
  );

  assign req_now       = update | refresh_hit;
  assign req_force_now = (update & force_all) | refresh_hit;
  // IDLE consumes a live request directly so the first word is two cycles out.
  assign take_req      = (state == IDLE) && (pend || req_now);

  assign ld_sel_a = cur_force | first_wr | (dac_a != last_a);
  assign ld_sel_b = cur_force | first_wr | (dac_b != last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_req) state_nxt = LOAD;
      LOAD: begin
        if (ld_sel_a)      state_nxt = SEND_A;
        else if (ld_sel_b) state_nxt = SEND_B;
        else               state_nxt = FINISH;
      end
      SEND_A:  if (m_axis_tready) state_nxt = sel_b ? SEND_B : FINISH;
      SEND_B:  if (m_axis_tready) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      pend_force <= 1'b0;
      cur_force  <= 1'b0;
      first_wr   <= 1'b1;
      snap_a     <= '0;
      snap_b     <= '0;
      snap_buf   <= 1'b0;
      snap_pd    <= '0;
      sel_b      <= 1'b0;
      last_a     <= '0;
      last_b     <= '0;
    end else begin
      if (take_req) begin
        cur_force  <= pend_force | req_force_now;
        pend       <= 1'b0;
        pend_force <= 1'b0;
      end else if (req_now) begin
        pend       <= 1'b1;
        pend_force <= pend_force | req_force_now;
      end
      if (state == LOAD) begin
        snap_a   <= dac_a;
        snap_b   <= dac_b;
        snap_buf <= buf_en;
        snap_pd  <= pd_mode;
        sel_b    <= ld_sel_b;
        first_wr <= 1'b0;
      end
      if ((state == SEND_A) && m_axis_tready) last_a <= snap_a;
      if ((state == SEND_B) && m_axis_tready) last_b <= snap_b;
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    word          = '0;
    case (state)
      SEND_A: begin
        m_axis_tvalid = 1'b1;
        word          = build_word(CH_A, snap_buf, snap_pd, snap_a);
      end
      SEND_B: begin
        m_axis_tvalid = 1'b1;
        word          = build_word(CH_B, snap_buf, snap_pd, snap_b);
      end
      default: ;
    endcase
  end

  assign m_axis_tdata = DATA_W'(word);
  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);

endmodule

// File: tb/tb_ad5302_cmd_seq.sv
// Self-checking bench for ad5302_cmd_seq: directed scenarios plus randomized
// updates checked against a channel-level reference model.
`timescale 1ns/1ps
module tb_ad5302_cmd_seq;

  typedef logic [15:0] wq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1, rst_r = 1'b1;
  logic       update = 1'b0, force_all = 1'b0, buf_en = 1'b0;
  logic [7:0] dac_a = '0, dac_b = '0;
  logic [1:0] pd_mode = '0;
  logic       ready_val = 1'b1, ready_mode = 1'b0, rnd_ready = 1'b1;
  logic       tready, tready_r = 1'b1;
  logic       tvalid, busy, done, tvalid_r, busy_r, done_r;
  logic [15:0] tdata, tdata_r;

  int tests_run = 0, tests_failed = 0;
  int done_cnt = 0, done_r_cnt = 0, cyc = 0;
  wq_t got_q, got_r_q, exp_q;
  int  got_r_t[$];

  logic [7:0] m_last_a, m_last_b;
  bit         m_first;

  assign tready = ready_mode ? rnd_ready : ready_val;

  always #5 clk = ~clk;

  ad5302_cmd_seq dut (
    .clk(clk), .rst(rst), .update(update), .force_all(force_all),
    .dac_a(dac_a), .dac_b(dac_b), .buf_en(buf_en), .pd_mode(pd_mode),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .busy(busy), .done(done)
  );

  ad5302_cmd_seq #(.REFRESH_CYCLES(100)) dut_r (
    .clk(clk), .rst(rst_r), .update(update), .force_all(force_all),
    .dac_a(dac_a), .dac_b(dac_b), .buf_en(buf_en), .pd_mode(pd_mode),
    .m_axis_tready(tready_r), .m_axis_tvalid(tvalid_r), .m_axis_tdata(tdata_r),
    .busy(busy_r), .done(done_r)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) #1 rnd_ready = 1'($urandom_range(0, 1));

  always @(negedge clk) begin
    if (tvalid && tready) got_q.push_back(tdata);
    if (done) done_cnt++;
    if (tvalid_r && tready_r) begin
      got_r_q.push_back(tdata_r);
      got_r_t.push_back(cyc);
    end
    if (done_r) done_r_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [15:0] mk(input logic ch, input logic bf,
                                     input logic [1:0] pd, input logic [7:0] d);
    return {ch, bf, pd, d, 4'b0000};
  endfunction

  function automatic bit q_same(input wq_t a, input wq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Expected words for one request given the values the sequencer will snapshot.
  task automatic model_seq(input logic [7:0] a, input logic [7:0] b, input logic bf,
                           input logic [1:0] pd, input bit frc);
    bit both;
    both = frc || m_first;
    if (both || (a != m_last_a)) begin exp_q.push_back(mk(1'b0, bf, pd, a)); m_last_a = a; end
    if (both || (b != m_last_b)) begin exp_q.push_back(mk(1'b1, bf, pd, b)); m_last_b = b; end
    m_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit frc);
    @(posedge clk); #1;
    update = 1'b1; force_all = frc;
    @(posedge clk); #1;
    update = 1'b0; force_all = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    #1;
    if (done_cnt < target) begin
      tests_run++; tests_failed++;
      $display("FAIL %s_timeout: done count %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ready_val = 1'b1;
    idle(3);
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_tvalid: got %b required 0", tvalid); end
    tests_run++; if (tdata !== 16'h0) begin tests_failed++; $display("FAIL rst_tdata: got %h required 0000", tdata); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b required 0", done); end
    rst = 1'b0;
    idle(3);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_quiet: busy %b required 0", busy); end
    m_last_a = '0; m_last_b = '0; m_first = 1'b1;
  endtask

  task automatic test_basic;
    wq_t want;
    int d0;
    dac_a = 8'h5A; dac_b = 8'hC3; buf_en = 1'b1; pd_mode = 2'd0;
    got_q.delete(); d0 = done_cnt;
    pulse(1'b0);
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL lat_early: tvalid %b required 0", tvalid); end
    idle(1);
    tests_run++; if (tvalid !== 1'b1) begin tests_failed++; $display("FAIL lat_2cyc: tvalid %b required 1", tvalid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_seq: busy %b required 1", busy); end
    wait_done(d0 + 1, 50, "basic");
    idle(4);
    want = '{16'h45A0, 16'hCC30};
    tests_run++; if (!q_same(got_q, want)) begin tests_failed++; $display("FAIL basic_words: got %p required %p", got_q, want); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL basic_done: pulses %0d required 1", done_cnt - d0); end
    model_seq(8'h5A, 8'hC3, 1'b1, 2'd0, 1'b0); exp_q.delete();

    dac_b = 8'h10; got_q.delete(); d0 = done_cnt;
    pulse(1'b0);
    wait_done(d0 + 1, 50, "changed_b");
    idle(4);
    want = '{16'hC100};
    tests_run++; if (!q_same(got_q, want)) begin tests_failed++; $display("FAIL changed_b_words: got %p required %p", got_q, want); end
    model_seq(8'h5A, 8'h10, 1'b1, 2'd0, 1'b0); exp_q.delete();
  endtask

  task automatic test_stall;
    logic [15:0] rec;
    bit stable;
    int d0;
    ready_val = 1'b0; dac_a = 8'h77;
    got_q.delete(); exp_q.delete(); d0 = done_cnt;
    model_seq(8'h77, 8'h10, 1'b1, 2'd0, 1'b0);
    pulse(1'b0);
    for (int i = 0; i < 10 && !tvalid; i++) idle(1);
    tests_run++; if (tvalid !== 1'b1 || tdata !== exp_q[0]) begin tests_failed++; $display("FAIL stall_word: tvalid %b tdata %h required 1 %h", tvalid, tdata, exp_q[0]); end
    rec = tdata; stable = 1'b1;
    repeat (20) begin
      idle(1);
      if (tvalid !== 1'b1 || tdata !== rec) stable = 1'b0;
    end
    tests_run++; if (!stable) begin tests_failed++; $display("FAIL stall_hold: tvalid %b tdata %h required 1 %h", tvalid, tdata, rec); end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL stall_no_xfer: transfers %0d required 0", got_q.size()); end
    ready_val = 1'b1;
    wait_done(d0 + 1, 50, "stall");
    idle(4);
    tests_run++; if (!q_same(got_q, exp_q)) begin tests_failed++; $display("FAIL stall_release: got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_pending;
    int d0;
    ready_val = 1'b0; dac_a = 8'h01; dac_b = 8'h02;
    got_q.delete(); exp_q.delete(); d0 = done_cnt;
    model_seq(8'h01, 8'h02, buf_en, pd_mode, 1'b0);
    pulse(1'b0);
    for (int i = 0; i < 10 && !tvalid; i++) idle(1);
    dac_a = 8'h03;
    pulse(1'b1); idle(1); pulse(1'b0); idle(1); pulse(1'b0);
    model_seq(8'h03, 8'h02, buf_en, pd_mode, 1'b1);
    ready_val = 1'b1;
    wait_done(d0 + 2, 100, "pending");
    idle(10);
    tests_run++; if (done_cnt - d0 != 2) begin tests_failed++; $display("FAIL pend_count: sequences %0d required 2", done_cnt - d0); end
    tests_run++; if (!q_same(got_q, exp_q)) begin tests_failed++; $display("FAIL pend_words: got %p required %p", got_q, exp_q); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL pend_idle: busy %b required 0", busy); end

    got_q.delete(); exp_q.delete(); d0 = done_cnt;
    model_seq(8'h03, 8'h02, buf_en, pd_mode, 1'b0);
    pulse(1'b0);
    wait_done(d0 + 1, 50, "nochange");
    idle(5);
    tests_run++; if (!q_same(got_q, exp_q)) begin tests_failed++; $display("FAIL nochange_words: got %p required %p", got_q, exp_q); end
    tests_run++; if (done_cnt - d0 != 1) begin tests_failed++; $display("FAIL nochange_done: pulses %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic bf;
    logic [1:0] pd;
    bit frc;
    int d0;
    ready_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      a   = ($urandom_range(0, 2) == 0) ? m_last_a : 8'($urandom);
      b   = ($urandom_range(0, 2) == 0) ? m_last_b : 8'($urandom);
      bf  = 1'($urandom_range(0, 1));
      pd  = 2'($urandom_range(0, 3));
      frc = ($urandom_range(0, 3) == 0);
      dac_a = a; dac_b = b; buf_en = bf; pd_mode = pd;
      got_q.delete(); exp_q.delete(); d0 = done_cnt;
      model_seq(a, b, bf, pd, frc);
      pulse(frc);
      wait_done(d0 + 1, 200, "random");
      idle(3);
      tests_run++; if (!q_same(got_q, exp_q)) begin tests_failed++; $display("FAIL random_%0d: got %p required %p", it, got_q, exp_q); end
    end
    ready_mode = 1'b0; ready_val = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid;
    int d0;
    ready_val = 1'b1; dac_a = 8'h21; dac_b = 8'h43; buf_en = 1'b0; pd_mode = 2'd3;
    got_q.delete();
    pulse(1'b1);
    for (int i = 0; i < 20 && !(tvalid && tdata[15]); i++) idle(1);
    ready_val = 1'b0;
    tests_run++; if (!(tvalid === 1'b1 && tdata[15] === 1'b1)) begin tests_failed++; $display("FAIL reach_send_b: tvalid %b ch %b required 1 1", tvalid, tdata[15]); end
    rst = 1'b1;
    idle(1);
    tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_tvalid: got %b required 0", tvalid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_idle: busy %b required 0", busy); end
    rst = 1'b0;
    m_last_a = '0; m_last_b = '0; m_first = 1'b1;
    idle(2);
    ready_val = 1'b1; got_q.delete(); exp_q.delete(); d0 = done_cnt;
    model_seq(8'h21, 8'h43, 1'b0, 2'd3, 1'b0);
    pulse(1'b0);
    wait_done(d0 + 1, 50, "after_rst");
    idle(4);
    tests_run++; if (!q_same(got_q, exp_q)) begin tests_failed++; $display("FAIL after_rst_words: got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_refresh;
    wq_t want;
    int dr0;
    bit found;
    dac_a = 8'h66; dac_b = 8'h99; buf_en = 1'b0; pd_mode = 2'd1;
    got_r_q.delete(); got_r_t.delete(); dr0 = done_r_cnt;
    rst_r = 1'b0;
    idle(350);
    want = '{mk(1'b0, 1'b0, 2'd1, 8'h66), mk(1'b1, 1'b0, 2'd1, 8'h99),
             mk(1'b0, 1'b0, 2'd1, 8'h66), mk(1'b1, 1'b0, 2'd1, 8'h99),
             mk(1'b0, 1'b0, 2'd1, 8'h66), mk(1'b1, 1'b0, 2'd1, 8'h99)};
    tests_run++; if (done_r_cnt - dr0 != 3) begin tests_failed++; $display("FAIL refresh_count: sequences %0d required 3", done_r_cnt - dr0); end
    tests_run++; if (!q_same(got_r_q, want)) begin tests_failed++; $display("FAIL refresh_words: got %p required %p", got_r_q, want); end
    tests_run++;
    if (got_r_t.size() < 6 || got_r_t[2] - got_r_t[0] != 100 || got_r_t[4] - got_r_t[2] != 100) begin
      tests_failed++; $display("FAIL refresh_period: times %p required spacing 100", got_r_t);
    end

    dac_a = 8'h67;
    found = 1'b0;
    for (int i = 0; i < 120 && !found; i++) begin
      idle(1);
      if (tvalid_r) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL refresh_seen: tvalid %b required 1", tvalid_r); end
    idle(10);
    got_r_q.delete(); dr0 = done_r_cnt;
    idle(87);
    pulse(1'b0);
    idle(60);
    want = '{mk(1'b0, 1'b0, 2'd1, 8'h67), mk(1'b1, 1'b0, 2'd1, 8'h99)};
    tests_run++; if (done_r_cnt - dr0 != 1) begin tests_failed++; $display("FAIL merge_count: sequences %0d required 1", done_r_cnt - dr0); end
    tests_run++; if (!q_same(got_r_q, want)) begin tests_failed++; $display("FAIL merge_words: got %p required %p", got_r_q, want); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_pending();
    test_random();
    test_reset_mid();
    test_refresh();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
